// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bundle: instruction memory port, redirect input and decode-side handshake.
// master = fetch queue, slave = memory/EX/decode side.
interface inst_fetch_queue_if #(
  parameter int CNT_W = 3
);
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_pc;
  logic [31:0]       id_inst;
  logic [CNT_W-1:0]  q_count;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_inst,
    output q_count
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_inst,
    input  q_count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential-PC fetch into a synchronous imem, buffering {pc, inst} for decode; redirect flushes all.
// Latency: request -> memory -> push, so an entry reaches decode 2 cycles after its request.
// Backpressure: issue only while registered count + in-flight < DEPTH; decode stalls via id_ready.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  logic [31:0]      fetch_pc;
  logic [31:0]      inflight_pc;
  logic             inflight_v;
  fetch_ent_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             push;
  logic             pop;
  fetch_ent_t       head;

  // Credit counts the registered occupancy only, so a same-cycle pop never frees a slot.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_v};
  assign issue     = !rst && !bus.redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
  assign push      = !rst && inflight_v && !bus.redirect_valid;
  assign pop       = bus.id_valid && bus.id_ready && !bus.redirect_valid;
  assign head      = mem[rd_ptr];

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.id_valid  = !rst && (count != '0);
  assign bus.id_pc     = head.pc;
  assign bus.id_inst   = head.inst;
  assign bus.q_count   = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: inflight_pc, inst: bus.imem_rdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC & ~32'h3;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (bus.redirect_valid) begin
      // The response for the in-flight request is discarded by clearing inflight_v.
      fetch_pc    <= bus.redirect_pc & ~32'h3;
      inflight_v  <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      inflight_v <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  push_never_full: assert property (@(posedge clk) disable iff (rst) push |-> (count < CNT_W'(DEPTH)));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: hand-computed cycle checks plus a scoreboard of expected PCs
// popped by a negedge monitor whenever decode accepts an entry.
module tb_inst_fetch_queue;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] exp_q [$];
  logic [31:0] sb_pc;

  inst_fetch_queue_if #(.CNT_W(3)) bus ();

  inst_fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4),
    .CNT_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous memory model: word returned one cycle after the request is addr>>2.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr >> 2;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  task automatic wait_qcount(input logic [31:0] target, input string nm);
    for (int i = 0; i < 12 && 32'(bus.q_count) != target; i++) step();
    chk(nm, 32'(bus.q_count), target);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.imem_req) chk("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
    if (!rst && bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty actual pc=%h required=no output at %0t", bus.id_pc, $time);
      end else begin
        sb_pc = exp_q.pop_front();
        chk("sb_pc", bus.id_pc, sb_pc);
        chk("sb_inst", bus.id_inst, sb_pc >> 2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;
    #1;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    step();
    step();
    chk("rst_q_count", 32'(bus.q_count), 32'd0);

    // 1: stream from reset
    exp_stream(32'h0);
    rst = 1'b0;
    #1;
    chk("t1_req0", 32'(bus.imem_req), 32'd1);
    chk("t1_addr0", bus.imem_addr, 32'h0);
    step();
    chk("t1_addr1", bus.imem_addr, 32'h4);
    chk("t1_latency_valid", 32'(bus.id_valid), 32'd0);
    step();
    chk("t1_first_valid", 32'(bus.id_valid), 32'd1);
    chk("t1_first_pc", bus.id_pc, 32'h0);
    chk("t1_first_inst", bus.id_inst, 32'h0);
    for (int k = 3; k <= 6; k++) begin
      step();
      chk("t1_stream_valid", 32'(bus.id_valid), 32'd1);
      chk("t1_stream_addr", bus.imem_addr, 32'(4 * k));
    end

    // 2: decode stall fills the queue, then drains in order
    bus.id_ready = 1'b0;
    #1;
    wait_qcount(32'd4, "t2_fill");
    chk("t2_req_stall", 32'(bus.imem_req), 32'd0);
    chk("t2_hold_pc", bus.id_pc, 32'h10);
    chk("t2_hold_inst", bus.id_inst, 32'h4);
    repeat (3) begin
      step();
      chk("t2_hold_pc", bus.id_pc, 32'h10);
      chk("t2_hold_count", 32'(bus.q_count), 32'd4);
    end
    bus.id_ready = 1'b1;
    #1;
    chk("t2_pop_no_credit", 32'(bus.imem_req), 32'd0);
    step();
    chk("t2_resume_req", 32'(bus.imem_req), 32'd1);
    chk("t2_resume_addr", bus.imem_addr, 32'h20);
    repeat (3) step();

    // 3: redirect with 3 queued and one in flight
    bus.id_ready = 1'b0;
    #1;
    wait_qcount(32'd3, "t3_fill");
    chk("t3_inflight_stall", 32'(bus.imem_req), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    exp_stream(32'h100);
    #1;
    chk("t3_redir_req", 32'(bus.imem_req), 32'd0);
    step();
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    #1;
    chk("t3_flush_count", 32'(bus.q_count), 32'd0);
    chk("t3_flush_valid", 32'(bus.id_valid), 32'd0);
    chk("t3_new_req", 32'(bus.imem_req), 32'd1);
    chk("t3_new_addr", bus.imem_addr, 32'h100);
    step();
    chk("t3_drop_old", 32'(bus.id_valid), 32'd0);
    step();
    chk("t3_new_valid", 32'(bus.id_valid), 32'd1);
    chk("t3_new_pc", bus.id_pc, 32'h100);
    repeat (4) step();

    // 4: back-to-back redirects, last (unaligned) one wins
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    exp_q.delete();
    #1;
    step();
    bus.redirect_pc = 32'h203;
    exp_stream(32'h200);
    #1;
    chk("t4_b2b_req", 32'(bus.imem_req), 32'd0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_align_addr", bus.imem_addr, 32'h200);
    chk("t4_count", 32'(bus.q_count), 32'd0);
    repeat (5) step();

    // 5: PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    exp_stream(32'hFFFF_FFF8);
    #1;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5_addr_fff8", bus.imem_addr, 32'hFFFF_FFF8);
    step();
    chk("t5_addr_fffc", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t5_wrap_addr", bus.imem_addr, 32'h0);
    repeat (4) step();

    // 6: reset overrides a same-cycle redirect
    bus.id_ready = 1'b0;
    #1;
    wait_qcount(32'd2, "t6_fill");
    rst                = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h400;
    exp_q.delete();
    #1;
    chk("t6_rst_req", 32'(bus.imem_req), 32'd0);
    chk("t6_rst_valid", 32'(bus.id_valid), 32'd0);
    step();
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    exp_stream(32'h0);
    #1;
    chk("t6_valid", 32'(bus.id_valid), 32'd0);
    chk("t6_count", 32'(bus.q_count), 32'd0);
    chk("t6_req", 32'(bus.imem_req), 32'd1);
    chk("t6_reset_pc", bus.imem_addr, 32'h0);
    step();
    step();
    chk("t6_first_valid", 32'(bus.id_valid), 32'd1);
    chk("t6_first_pc", bus.id_pc, 32'h0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
